// File: rtl/tlb_miss_sequencer_if.sv
// Bundle of TLB-miss, page-walk and fill/fault signals between the miss sequencer and its neighbours.
// The slave modport is the sequencer's view; the master modport is the surrounding logic's view.
interface tlb_miss_sequencer_if #(
  parameter int THR_PER_CORE_WIDTH = 2,
  parameter int VIRT_ADDR_WIDTH    = 32,
  parameter int PHY_ADDR_WIDTH     = 20
);
  logic                          itlb_miss_valid;
  logic                          itlb_miss_ready;
  logic [THR_PER_CORE_WIDTH-1:0] itlb_miss_thread_id;
  logic [VIRT_ADDR_WIDTH-1:0]    itlb_miss_virt_addr;
  logic                          dtlb_miss_valid;
  logic                          dtlb_miss_ready;
  logic [THR_PER_CORE_WIDTH-1:0] dtlb_miss_thread_id;
  logic [VIRT_ADDR_WIDTH-1:0]    dtlb_miss_virt_addr;
  logic                          walk_req_valid;
  logic                          walk_req_ready;
  logic [VIRT_ADDR_WIDTH-1:0]    walk_req_virt_addr;
  logic [THR_PER_CORE_WIDTH-1:0] walk_req_thread_id;
  logic                          walk_rsp_valid;
  logic [PHY_ADDR_WIDTH-1:0]     walk_rsp_phy_addr;
  logic                          walk_rsp_fault;
  logic                          itlb_new_entry;
  logic                          dtlb_new_entry;
  logic [THR_PER_CORE_WIDTH-1:0] new_tlb_thread_id;
  logic [VIRT_ADDR_WIDTH-1:0]    new_tlb_virt_addr;
  logic [PHY_ADDR_WIDTH-1:0]     new_tlb_phy_addr;
  logic                          fault_valid;
  logic                          fault_is_data;
  logic [THR_PER_CORE_WIDTH-1:0] fault_thread_id;
  logic [VIRT_ADDR_WIDTH-1:0]    fault_virt_addr;
  logic                          busy;
  logic                          timeout_err;

  modport slave (
    input  itlb_miss_valid, itlb_miss_thread_id, itlb_miss_virt_addr,
    input  dtlb_miss_valid, dtlb_miss_thread_id, dtlb_miss_virt_addr,
    input  walk_req_ready, walk_rsp_valid, walk_rsp_phy_addr, walk_rsp_fault,
    output itlb_miss_ready, dtlb_miss_ready,
    output walk_req_valid, walk_req_virt_addr, walk_req_thread_id,
    output itlb_new_entry, dtlb_new_entry, new_tlb_thread_id, new_tlb_virt_addr, new_tlb_phy_addr,
    output fault_valid, fault_is_data, fault_thread_id, fault_virt_addr, busy, timeout_err
  );

  modport master (
    output itlb_miss_valid, itlb_miss_thread_id, itlb_miss_virt_addr,
    output dtlb_miss_valid, dtlb_miss_thread_id, dtlb_miss_virt_addr,
    output walk_req_ready, walk_rsp_valid, walk_rsp_phy_addr, walk_rsp_fault,
    input  itlb_miss_ready, dtlb_miss_ready,
    input  walk_req_valid, walk_req_virt_addr, walk_req_thread_id,
    input  itlb_new_entry, dtlb_new_entry, new_tlb_thread_id, new_tlb_virt_addr, new_tlb_phy_addr,
    input  fault_valid, fault_is_data, fault_thread_id, fault_virt_addr, busy, timeout_err
  );
endinterface

// File: rtl/tlb_miss_sequencer.sv
// Serialises I-TLB / D-TLB misses into one page walk at a time and returns fills or faults.
// Optional WAIT-state watchdog enabled by defining TLB_MISS_TIMEOUT_EN.
module tlb_miss_sequencer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  tlb_miss_sequencer_if.slave   io_tlb
);
  localparam int THR_W = 2;
  localparam int VA_W  = 32;
  localparam int PA_W  = 20;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_last_data, w_last_data_nxt;
  logic               r_src_data, w_src_data_nxt;
  logic [THR_W-1:0]   r_thr, w_thr_nxt;
  logic [VA_W-1:0]    r_va, w_va_nxt;
  logic               r_walk_req_valid, w_walk_req_valid_nxt;
  logic               r_itlb_new, w_itlb_new_nxt;
  logic               r_dtlb_new, w_dtlb_new_nxt;
  logic [THR_W-1:0]   r_new_thr, w_new_thr_nxt;
  logic [VA_W-1:0]    r_new_va, w_new_va_nxt;
  logic [PA_W-1:0]    r_new_pa, w_new_pa_nxt;
  logic               r_fault_valid, w_fault_valid_nxt;
  logic               r_fault_is_data, w_fault_is_data_nxt;
  logic [THR_W-1:0]   r_fault_thr, w_fault_thr_nxt;
  logic [VA_W-1:0]    r_fault_va, w_fault_va_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_timeout_err, w_timeout_err_nxt;
  logic               w_grant_i, w_grant_d, w_to_hit;

  // On a tie the side not granted last wins; r_last_data=1 means data went last.
  assign w_grant_i = io_tlb.itlb_miss_valid & (~io_tlb.dtlb_miss_valid | r_last_data);
  assign w_grant_d = io_tlb.dtlb_miss_valid & (~io_tlb.itlb_miss_valid | ~r_last_data);
  assign io_tlb.itlb_miss_ready = (r_state == ST_IDLE) & w_grant_i;
  assign io_tlb.dtlb_miss_ready = (r_state == ST_IDLE) & w_grant_d;

`ifdef TLB_MISS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_to_cnt;

  assign w_to_hit = (r_state == ST_WAIT) && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter, held at zero outside WAIT so it starts clean on entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // Next-state and next-output logic; a real response beats a coincident timeout.
  always_comb begin
    w_state_nxt         = r_state;
    w_last_data_nxt     = r_last_data;
    w_src_data_nxt      = r_src_data;
    w_thr_nxt           = r_thr;
    w_va_nxt            = r_va;
    w_itlb_new_nxt      = 1'b0;
    w_dtlb_new_nxt      = 1'b0;
    w_new_thr_nxt       = r_new_thr;
    w_new_va_nxt        = r_new_va;
    w_new_pa_nxt        = r_new_pa;
    w_fault_valid_nxt   = 1'b0;
    w_fault_is_data_nxt = r_fault_is_data;
    w_fault_thr_nxt     = r_fault_thr;
    w_fault_va_nxt      = r_fault_va;
    w_timeout_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_i || w_grant_d) begin
          w_state_nxt     = ST_REQ;
          w_last_data_nxt = w_grant_d;
          w_src_data_nxt  = w_grant_d;
          w_thr_nxt       = w_grant_d ? io_tlb.dtlb_miss_thread_id : io_tlb.itlb_miss_thread_id;
          w_va_nxt        = w_grant_d ? io_tlb.dtlb_miss_virt_addr : io_tlb.itlb_miss_virt_addr;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (io_tlb.walk_req_ready) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (io_tlb.walk_rsp_valid && !io_tlb.walk_rsp_fault) begin
          w_state_nxt    = ST_FILL;
          w_itlb_new_nxt = ~r_src_data;
          w_dtlb_new_nxt = r_src_data;
          w_new_thr_nxt  = r_thr;
          w_new_va_nxt   = r_va;
          w_new_pa_nxt   = io_tlb.walk_rsp_phy_addr;
        end else if (io_tlb.walk_rsp_valid || w_to_hit) begin
          w_state_nxt         = ST_IDLE;
          w_fault_valid_nxt   = 1'b1;
          w_fault_is_data_nxt = r_src_data;
          w_fault_thr_nxt     = r_thr;
          w_fault_va_nxt      = r_va;
          w_timeout_err_nxt   = ~io_tlb.walk_rsp_valid;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_FILL: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_walk_req_valid_nxt = (w_state_nxt == ST_REQ);
    w_busy_nxt           = (w_state_nxt != ST_IDLE);
  end

  // State, latched request and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= ST_IDLE;
      r_last_data      <= 1'b1;
      r_src_data       <= 1'b0;
      r_thr            <= '0;
      r_va             <= '0;
      r_walk_req_valid <= 1'b0;
      r_itlb_new       <= 1'b0;
      r_dtlb_new       <= 1'b0;
      r_new_thr        <= '0;
      r_new_va         <= '0;
      r_new_pa         <= '0;
      r_fault_valid    <= 1'b0;
      r_fault_is_data  <= 1'b0;
      r_fault_thr      <= '0;
      r_fault_va       <= '0;
      r_busy           <= 1'b0;
      r_timeout_err    <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_last_data      <= w_last_data_nxt;
      r_src_data       <= w_src_data_nxt;
      r_thr            <= w_thr_nxt;
      r_va             <= w_va_nxt;
      r_walk_req_valid <= w_walk_req_valid_nxt;
      r_itlb_new       <= w_itlb_new_nxt;
      r_dtlb_new       <= w_dtlb_new_nxt;
      r_new_thr        <= w_new_thr_nxt;
      r_new_va         <= w_new_va_nxt;
      r_new_pa         <= w_new_pa_nxt;
      r_fault_valid    <= w_fault_valid_nxt;
      r_fault_is_data  <= w_fault_is_data_nxt;
      r_fault_thr      <= w_fault_thr_nxt;
      r_fault_va       <= w_fault_va_nxt;
      r_busy           <= w_busy_nxt;
      r_timeout_err    <= w_timeout_err_nxt;
    end
  end

  assign io_tlb.walk_req_valid     = r_walk_req_valid;
  assign io_tlb.walk_req_virt_addr = r_va;
  assign io_tlb.walk_req_thread_id = r_thr;
  assign io_tlb.itlb_new_entry     = r_itlb_new;
  assign io_tlb.dtlb_new_entry     = r_dtlb_new;
  assign io_tlb.new_tlb_thread_id  = r_new_thr;
  assign io_tlb.new_tlb_virt_addr  = r_new_va;
  assign io_tlb.new_tlb_phy_addr   = r_new_pa;
  assign io_tlb.fault_valid        = r_fault_valid;
  assign io_tlb.fault_is_data      = r_fault_is_data;
  assign io_tlb.fault_thread_id    = r_fault_thr;
  assign io_tlb.fault_virt_addr    = r_fault_va;
  assign io_tlb.busy               = r_busy;
  assign io_tlb.timeout_err        = r_timeout_err;
endmodule

// File: tb/tb_tlb_miss_sequencer.sv
// Self-checking bench for tlb_miss_sequencer: expected fills/faults are queued at accept
// time and compared when the DUT strobes them.
module tb_tlb_miss_sequencer;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tlb_miss_sequencer_if bus();
  tlb_miss_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_tlb (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic        flt;
    logic        to;
    logic        dat;
    logic [1:0]  thr;
    logic [31:0] va;
    logic [19:0] pa;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.itlb_new_entry || bus.dtlb_new_entry || bus.fault_valid)) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("sb_kind", {bus.itlb_new_entry, bus.dtlb_new_entry, bus.fault_valid},
                  mon_e.flt ? 3'b001 : (mon_e.dat ? 3'b010 : 3'b100));
        check_val("sb_timeout", bus.timeout_err, mon_e.to);
        if (mon_e.flt) begin
          check_val("sb_fault_is_data", bus.fault_is_data, mon_e.dat);
          check_val("sb_fault_thr", bus.fault_thread_id, mon_e.thr);
          check_val("sb_fault_va", bus.fault_virt_addr, mon_e.va);
        end else begin
          check_val("sb_new_thr", bus.new_tlb_thread_id, mon_e.thr);
          check_val("sb_new_va", bus.new_tlb_virt_addr, mon_e.va);
          check_val("sb_new_pa", bus.new_tlb_phy_addr, mon_e.pa);
        end
      end
    end
  end

  task automatic accept(input bit dat, input logic [1:0] thr, input logic [31:0] va,
                        input logic [19:0] pa, input bit flt, input bit to);
    if (dat) begin
      bus.dtlb_miss_valid = 1'b1; bus.dtlb_miss_thread_id = thr; bus.dtlb_miss_virt_addr = va;
    end else begin
      bus.itlb_miss_valid = 1'b1; bus.itlb_miss_thread_id = thr; bus.itlb_miss_virt_addr = va;
    end
    #1;
    check_val("grant", {bus.itlb_miss_ready, bus.dtlb_miss_ready}, dat ? 2'b01 : 2'b10);
    exp_q.push_back('{flt, to, dat, thr, va, pa});
    tick();
    bus.itlb_miss_valid = 1'b0;
    bus.dtlb_miss_valid = 1'b0;
    check_val("req_valid_n1", bus.walk_req_valid, 1'b1);
    check_val("req_va", bus.walk_req_virt_addr, va);
    check_val("req_thr", bus.walk_req_thread_id, thr);
    check_val("busy", bus.busy, 1'b1);
  endtask

  // Called one cycle after accept (REQ state); ends in the IDLE cycle after the strobe.
  task automatic walk(input bit dat, input logic [1:0] thr, input logic [31:0] va,
                      input logic [19:0] pa, input bit flt, input int stall);
    for (int i = 0; i < stall; i++) begin
      check_val("stall_valid", bus.walk_req_valid, 1'b1);
      check_val("stall_va", bus.walk_req_virt_addr, va);
      check_val("stall_thr", bus.walk_req_thread_id, thr);
      if (i == 2) begin
        bus.dtlb_miss_valid = 1'b1;
        bus.dtlb_miss_virt_addr = 32'hDEAD_0000;
        #1;
        check_val("busy_no_ready", bus.dtlb_miss_ready, 1'b0);
      end else begin
        bus.dtlb_miss_valid = 1'b0;
      end
      tick();
    end
    bus.dtlb_miss_valid = 1'b0;
    bus.walk_req_ready = 1'b1;
    tick();
    bus.walk_req_ready = 1'b0;
    check_val("wait_no_req", bus.walk_req_valid, 1'b0);
    bus.walk_rsp_valid = 1'b1; bus.walk_rsp_phy_addr = pa; bus.walk_rsp_fault = flt;
    tick();
    bus.walk_rsp_valid = 1'b0; bus.walk_rsp_fault = 1'b0;
    check_val("pulse_n3", {bus.itlb_new_entry, bus.dtlb_new_entry, bus.fault_valid},
              flt ? 3'b001 : (dat ? 3'b010 : 3'b100));
    tick();
    check_val("pulse_end", {bus.itlb_new_entry, bus.dtlb_new_entry, bus.fault_valid}, 3'b000);
    if (flt) check_val("fault_va_hold", bus.fault_virt_addr, va);
    else     check_val("new_va_hold", bus.new_tlb_virt_addr, va);
    if (!flt) tick();
    check_val("idle_busy", bus.busy, 1'b0);
  endtask

  task automatic tie(input bit exp_d, input logic [31:0] va_i, input logic [31:0] va_d);
    bus.itlb_miss_valid = 1'b1; bus.itlb_miss_thread_id = 2'd1; bus.itlb_miss_virt_addr = va_i;
    bus.dtlb_miss_valid = 1'b1; bus.dtlb_miss_thread_id = 2'd2; bus.dtlb_miss_virt_addr = va_d;
    #1;
    check_val("tie_grant", {bus.itlb_miss_ready, bus.dtlb_miss_ready}, exp_d ? 2'b01 : 2'b10);
    exp_q.push_back('{1'b0, 1'b0, exp_d, exp_d ? 2'd2 : 2'd1, exp_d ? va_d : va_i, 20'h11111});
    tick();
    bus.itlb_miss_valid = 1'b0;
    bus.dtlb_miss_valid = 1'b0;
    check_val("tie_req_va", bus.walk_req_virt_addr, exp_d ? va_d : va_i);
    walk(exp_d, exp_d ? 2'd2 : 2'd1, exp_d ? va_d : va_i, 20'h11111, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.itlb_miss_valid = 1'b0; bus.itlb_miss_thread_id = 2'd0; bus.itlb_miss_virt_addr = 32'd0;
    bus.dtlb_miss_valid = 1'b0; bus.dtlb_miss_thread_id = 2'd0; bus.dtlb_miss_virt_addr = 32'd0;
    bus.walk_req_ready = 1'b0; bus.walk_rsp_valid = 1'b0;
    bus.walk_rsp_phy_addr = 20'd0; bus.walk_rsp_fault = 1'b0;
    tick(); tick();
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_req_valid", bus.walk_req_valid, 1'b0);
    check_val("rst_strobes", {bus.itlb_new_entry, bus.dtlb_new_entry, bus.fault_valid,
              bus.timeout_err}, 4'b0000);
    check_val("rst_fields", {bus.new_tlb_virt_addr, bus.new_tlb_phy_addr}, 52'd0);
    rst_n = 1'b1;
    tick();

    tie(1'b0, 32'h1000_0000, 32'h2000_0000);
    tie(1'b1, 32'h1000_1000, 32'h2000_1000);
    tie(1'b0, 32'h1000_2000, 32'h2000_2000);

    accept(1'b0, 2'd1, 32'h0040_1000, 20'h2A3F1, 1'b0, 1'b0);
    walk(1'b0, 2'd1, 32'h0040_1000, 20'h2A3F1, 1'b0, 0);

    accept(1'b1, 2'd2, 32'h8000_0000, 20'h0, 1'b1, 1'b0);
    walk(1'b1, 2'd2, 32'h8000_0000, 20'h0, 1'b1, 0);

    accept(1'b0, 2'd3, 32'hCAFE_F000, 20'h0ABCD, 1'b0, 1'b0);
    walk(1'b0, 2'd3, 32'hCAFE_F000, 20'h0ABCD, 1'b0, 5);

    for (int i = 0; i < 3; i++) begin
      bus.walk_rsp_valid = 1'b1; bus.walk_rsp_phy_addr = 20'h55555; bus.walk_rsp_fault = i[0];
      tick();
      check_val("spur_busy", bus.busy, 1'b0);
      check_val("spur_pa_hold", bus.new_tlb_phy_addr, 20'h0ABCD);
    end
    bus.walk_rsp_valid = 1'b0; bus.walk_rsp_fault = 1'b0;
    tick();

`ifdef TLB_MISS_TIMEOUT_EN
    accept(1'b0, 2'd3, 32'h1234_5000, 20'h0, 1'b1, 1'b1);
    bus.walk_req_ready = 1'b1;
    tick();
    bus.walk_req_ready = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      check_val("to_quiet", bus.timeout_err, 1'b0);
      tick();
    end
    tick();
    check_val("to_pulse", {bus.timeout_err, bus.fault_valid}, 2'b11);
    tick();
    check_val("to_end", {bus.timeout_err, bus.fault_valid, bus.busy}, 3'b000);
    bus.walk_rsp_valid = 1'b1; bus.walk_rsp_phy_addr = 20'h77777;
    tick();
    bus.walk_rsp_valid = 1'b0;
    tick();
    check_val("late_rsp_ignored", {bus.itlb_new_entry, bus.busy}, 2'b00);
    accept(1'b1, 2'd1, 32'h0BAD_0000, 20'h0, 1'b0, 1'b0);
    bus.walk_req_ready = 1'b1;
    tick();
    bus.walk_req_ready = 1'b0;
`else
    accept(1'b1, 2'd1, 32'h0BAD_0000, 20'h0, 1'b0, 1'b0);
    bus.walk_req_ready = 1'b1;
    tick();
    bus.walk_req_ready = 1'b0;
    repeat (20) tick();
    check_val("wait_forever", {bus.busy, bus.timeout_err}, 2'b10);
`endif

    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_busy", bus.busy, 1'b0);
    check_val("async_rst_fields", {bus.walk_req_valid, bus.new_tlb_virt_addr}, 33'd0);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    bus.walk_rsp_valid = 1'b1; bus.walk_rsp_phy_addr = 20'h33333;
    tick();
    bus.walk_rsp_valid = 1'b0;
    check_val("post_rst_nofill", {bus.itlb_new_entry, bus.dtlb_new_entry, bus.busy}, 3'b000);
    tick();
    check_val("post_rst_pa", bus.new_tlb_phy_addr, 20'h0);

    tie(1'b0, 32'h1000_3000, 32'h2000_3000);

    tick();
    check_val("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/tlb_miss_sequencer.md
TLB_MISS_SEQUENCER -- requirements
Module: tlb_miss_sequencer

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 256, WAIT-state cycles before abort (TLB_MISS_TIMEOUT_EN only; min 2).
REQ-002 SHALL have: clock  in  1  single clock; all flops rising-edge.
REQ-003 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have: itlb_miss_valid / itlb_miss_ready  in/out  1  instruction-TLB miss handshake.
REQ-005 SHALL have: itlb_miss_thread_id  in  THR_PER_CORE_WIDTH (2); itlb_miss_virt_addr  in  VIRT_ADDR_WIDTH (32).
REQ-006 SHALL have: dtlb_miss_valid / dtlb_miss_ready, dtlb_miss_thread_id, dtlb_miss_virt_addr; same widths, data-TLB side.
REQ-007 SHALL have: walk_req_valid out 1; walk_req_ready in 1; walk_req_virt_addr out 32; walk_req_thread_id out 2.
REQ-008 SHALL have: walk_rsp_valid in 1; walk_rsp_phy_addr in PHY_ADDR_WIDTH (20); walk_rsp_fault in 1.
REQ-009 SHALL have: itlb_new_entry out 1; dtlb_new_entry out 1; new_tlb_thread_id out 2; new_tlb_virt_addr out 32; new_tlb_phy_addr out 20.
REQ-010 SHALL have: fault_valid out 1; fault_is_data out 1; fault_thread_id out 2; fault_virt_addr out 32; busy out 1; timeout_err out 1.

Function
REQ-011 SHALL implement FSM IDLE, REQ, WAIT, FILL; busy = (state != IDLE).
REQ-012 IDLE: ready SHALL be high only toward the arbitration winner, combinationally; both readys low in all other states.
REQ-013 Arbitration SHALL be round-robin: on a tie, grant the side not granted last; a lone valid always wins.
REQ-014 On accept (valid & ready), SHALL latch source, thread id and VA, and enter REQ next cycle.
REQ-015 REQ: walk_req_valid=1 with latched VA/thread held stable; on walk_req_ready -> WAIT next cycle.
REQ-016 WAIT: on walk_rsp_valid & !walk_rsp_fault -> latch PA, go FILL; walk_rsp_valid & walk_rsp_fault -> one-cycle fault_valid with latched source/thread/VA, go IDLE.
REQ-017 FILL: exactly one one-cycle pulse on itlb_new_entry or dtlb_new_entry (per source) with new_tlb_* fields valid that cycle; -> IDLE next cycle.
REQ-018 walk_rsp_valid outside WAIT SHALL be ignored with no state or output change.
REQ-019 Latency: accept in cycle N, walk_req_valid in N+1; with walk_req_ready in N+1 and rsp in N+2, fill pulse in N+3.
REQ-020 A new miss SHALL be acceptable in the cycle the FSM is in IDLE after FILL or fault (one-cycle dead time minimum).
REQ-021 A requester whose valid drops before accept SHALL not be served; no request queuing beyond the one in flight.
REQ-022 new_tlb_*, fault_* fields SHALL hold last values when their strobes are low; outputs are registered except readys.

Reset
REQ-023 reset low SHALL asynchronously force IDLE, round-robin pointer to favour instruction side, all strobes, busy, walk_req_valid, timeout_err to 0 and latched fields to 0.
REQ-024 Reset mid-operation SHALL abandon the in-flight walk; any walk_rsp_valid after release is ignored per REQ-018.

Configuration
REQ-025 Macro TLB_MISS_TIMEOUT_EN defined: a counter clears on WAIT entry, increments each WAIT cycle; reaching TIMEOUT_CYCLES without response SHALL pulse timeout_err and fault_valid for one cycle and return to IDLE.
REQ-026 Macro undefined: no counter, WAIT lasts indefinitely, timeout_err tied 0.

Verification
REQ-027 itlb miss VA=0x0040_1000 thr=1, ready immediate, rsp PA=0x2A3F1 no fault -> itlb_new_entry pulse 3 cycles after accept, fields 0x0040_1000/1/0x2A3F1, dtlb_new_entry stays 0.
REQ-028 itlb and dtlb valid together from reset, twice back-to-back -> grants instr then data; next tie grants instr.
REQ-029 dtlb miss thr=2 VA=0x8000_0000, rsp with walk_rsp_fault=1 -> fault_valid one cycle, fault_is_data=1, thread 2, VA 0x8000_0000; no new_entry pulse.
REQ-030 walk_req_ready held low 5 cycles -> walk_req_valid and fields stable 5 cycles; spurious walk_rsp_valid while in IDLE -> no outputs.
REQ-031 TLB_MISS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no rsp -> timeout_err and fault_valid after 8 WAIT cycles; late rsp ignored; without macro FSM stays in WAIT.
REQ-032 reset asserted in WAIT -> busy=0 immediately (async); after release a response causes no fill.
